// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access controller.
// Holds the command opcode encoding, the controller state enum and the
// default address / data / block-length widths.
package ram_ctrl_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int DATA_SIZE_DEF = 8;
    // One bit wider than the address, so a full 2^addr_size block is expressible.
    localparam int LEN_SIZE_DEF  = ADDR_SIZE_DEF + 1;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_FILL  = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        CP_RD,
        CP_WAIT,
        CP_WR,
        FILL,
        FIN
    } state_e;

endpackage

// File: rtl/ram_blk_counter.sv
// Block address/length tracker for COPY and FILL.
// Holds a source and destination address pair plus a shared down-counter of
// remaining words. load captures a new block; step advances both addresses
// (modulo 2^addr_size) and consumes one word.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load                  capture src_in / dst_in / len_in
//   step                  advance to the next word
//   src_in, dst_in        block start addresses
//   len_in                block word count
//   src, dst              address of the current word
//   last                  exactly one word remains (the current one)
//   zero                  no words remain
module ram_blk_counter #(
    parameter int addr_size = 8,
    parameter int len_size  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [addr_size-1:0] src_in,
    input  logic [addr_size-1:0] dst_in,
    input  logic [len_size-1:0]  len_in,
    output logic [addr_size-1:0] src,
    output logic [addr_size-1:0] dst,
    output logic                 last,
    output logic                 zero
);

    typedef logic [addr_size-1:0] addr_t;
    typedef logic [len_size-1:0]  len_t;

    addr_t src_reg;
    addr_t dst_reg;
    len_t  rem_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_reg <= '0;
            dst_reg <= '0;
            rem_reg <= '0;
        end else if (load) begin
            src_reg <= src_in;
            dst_reg <= dst_in;
            rem_reg <= len_in;
        end else if (step && (rem_reg != '0)) begin
            // Address overflow wraps naturally at addr_size bits.
            src_reg <= src_reg + addr_t'(1);
            dst_reg <= dst_reg + addr_t'(1);
            rem_reg <= rem_reg - len_t'(1);
        end
    end

    assign src  = src_reg;
    assign dst  = dst_reg;
    assign last = (rem_reg == len_t'(1));
    assign zero = (rem_reg == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Memory access controller between the CPU datapath and a data RAM with one
// cycle of read latency. Executes READ, WRITE, COPY and FILL commands
// received over a valid/ready handshake and sequences the RAM strobes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only when idle)
//   cmd_op                        00 READ, 01 WRITE, 10 COPY, 11 FILL
//   cmd_addr, cmd_addr2           address / COPY source, COPY destination
//   cmd_len, cmd_data             block length, write data / fill pattern
//   rsp_valid, rsp_data           READ result pulse and held data
//   done, busy                    completion pulse, not-idle flag
//   ram_*                         RAM write port, read port and read data
// All outputs are registered: each is computed from the next state and
// loaded on the same edge as the state register.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE_DEF,
    parameter int data_size = DATA_SIZE_DEF,
    parameter int len_size  = LEN_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [addr_size-1:0] cmd_addr,
    input  logic [addr_size-1:0] cmd_addr2,
    input  logic [len_size-1:0]  cmd_len,
    input  logic [data_size-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [data_size-1:0] rsp_data,
    output logic                 done,
    output logic                 busy,
    output logic                 ram_write_en,
    output logic [addr_size-1:0] ram_write_adress,
    output logic [data_size-1:0] ram_data_in,
    output logic                 ram_rd_en,
    output logic [addr_size-1:0] ram_rd_adress,
    input  logic [data_size-1:0] ram_data_out
);

    typedef logic [addr_size-1:0] addr_t;
    typedef logic [data_size-1:0] data_t;

    state_e state_reg, state_next;

    logic  rd_en_reg,     rd_en_next;
    addr_t rd_addr_reg,   rd_addr_next;
    logic  wr_en_reg,     wr_en_next;
    addr_t wr_addr_reg,   wr_addr_next;
    data_t data_in_reg,   data_in_next;
    logic  rsp_valid_reg, rsp_valid_next;
    data_t rsp_data_reg,  rsp_data_next;
    logic  done_reg,      done_next;
    logic  ready_reg;
    logic  busy_reg;

    logic  cnt_load;
    logic  cnt_step;
    addr_t cnt_src;
    addr_t cnt_dst;
    logic  cnt_last;
    logic  cnt_zero;

    ram_blk_counter #(
        .addr_size (addr_size),
        .len_size  (len_size)
    ) u_blk_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .step   (cnt_step),
        .src_in (cmd_addr),
        .dst_in (cmd_addr2),
        .len_in (cmd_len),
        .src    (cnt_src),
        .dst    (cnt_dst),
        .last   (cnt_last),
        .zero   (cnt_zero)
    );

    always_comb begin
        state_next     = state_reg;
        rd_en_next     = 1'b0;
        rd_addr_next   = rd_addr_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        data_in_next   = data_in_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        done_next      = 1'b0;
        cnt_load       = 1'b0;
        cnt_step       = 1'b0;

        case (state_reg)
            IDLE: begin
                // cmd_ready is high exactly while IDLE, so valid alone accepts.
                if (cmd_valid) begin
                    cnt_load = 1'b1;
                    case (op_e'(cmd_op))
                        OP_READ: begin
                            state_next   = RD;
                            rd_en_next   = 1'b1;
                            rd_addr_next = cmd_addr;
                        end
                        OP_WRITE: begin
                            state_next   = WR;
                            wr_en_next   = 1'b1;
                            wr_addr_next = cmd_addr;
                            data_in_next = cmd_data;
                        end
                        OP_COPY: begin
                            if (cmd_len == '0) begin
                                state_next = FIN;
                                done_next  = 1'b1;
                            end else begin
                                state_next   = CP_RD;
                                rd_en_next   = 1'b1;
                                rd_addr_next = cmd_addr;
                            end
                        end
                        OP_FILL: begin
                            if (cmd_len == '0) begin
                                state_next = FIN;
                                done_next  = 1'b1;
                            end else begin
                                state_next   = FILL;
                                wr_en_next   = 1'b1;
                                wr_addr_next = cmd_addr;
                                data_in_next = cmd_data;
                            end
                        end
                    endcase
                end
            end
            RD: state_next = RD_WAIT;
            RD_WAIT: begin
                // RAM output is valid in this cycle; capture it for the response.
                state_next     = IDLE;
                rsp_valid_next = 1'b1;
                rsp_data_next  = ram_data_out;
                done_next      = 1'b1;
            end
            WR: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            CP_RD: state_next = CP_WAIT;
            CP_WAIT: begin
                state_next   = CP_WR;
                wr_en_next   = 1'b1;
                wr_addr_next = cnt_dst;
                data_in_next = ram_data_out;
            end
            CP_WR: begin
                cnt_step = 1'b1;
                if (cnt_last || cnt_zero) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    // Counter still points at the word just written.
                    state_next   = CP_RD;
                    rd_en_next   = 1'b1;
                    rd_addr_next = cnt_src + addr_t'(1);
                end
            end
            FILL: begin
                cnt_step = 1'b1;
                if (cnt_last || cnt_zero) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = cnt_src + addr_t'(1);
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            data_in_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            done_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_en_reg     <= rd_en_next;
            rd_addr_reg   <= rd_addr_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            data_in_reg   <= data_in_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            done_reg      <= done_next;
            ready_reg     <= (state_next == IDLE);
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign cmd_ready        = ready_reg;
    assign busy             = busy_reg;
    assign rsp_valid        = rsp_valid_reg;
    assign rsp_data         = rsp_data_reg;
    assign done             = done_reg;
    assign ram_write_en     = wr_en_reg;
    assign ram_write_adress = wr_addr_reg;
    assign ram_data_in      = data_in_reg;
    assign ram_rd_en        = rd_en_reg;
    assign ram_rd_adress    = rd_addr_reg;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl with a behavioural single-cycle-latency RAM.
// Table-driven command vectors plus hand-written timing sequences.
module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_addr2;
    logic [8:0] cmd_len;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;
    logic       busy;
    logic       ram_write_en;
    logic [7:0] ram_write_adress;
    logic [7:0] ram_data_in;
    logic       ram_rd_en;
    logic [7:0] ram_rd_adress;
    logic [7:0] ram_data_out;

    localparam logic [1:0] C_READ  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_COPY  = 2'b10;
    localparam logic [1:0] C_FILL  = 2'b11;

    int total = 0;
    int bad = 0;
    int overlap_cnt = 0;
    int rstpulse_cnt = 0;

    logic [7:0] mem [256];

    ram_access_ctrl #(
        .addr_size (8),
        .data_size (8),
        .len_size  (9)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_addr2        (cmd_addr2),
        .cmd_len          (cmd_len),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .done             (done),
        .busy             (busy),
        .ram_write_en     (ram_write_en),
        .ram_write_adress (ram_write_adress),
        .ram_data_in      (ram_data_in),
        .ram_rd_en        (ram_rd_en),
        .ram_rd_adress    (ram_rd_adress),
        .ram_data_out     (ram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_adress] <= ram_data_in;
        if (ram_rd_en)    ram_data_out <= mem[ram_rd_adress];
    end

    always @(negedge clk) begin
        if (ram_rd_en && ram_write_en) overlap_cnt++;
        if (rst && (done || rsp_valid)) rstpulse_cnt++;
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] addr2;
        logic [8:0] len;
        logic [7:0] data;
        int         lat;
        int         nwr;
        int         nrd;
        logic [7:0] rsp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] op, logic [7:0] addr, logic [7:0] addr2,
                                logic [8:0] len, logic [7:0] data, int lat, int nwr,
                                int nrd, logic [7:0] rsp);
        vec_t v;
        v.op = op; v.addr = addr; v.addr2 = addr2; v.len = len; v.data = data;
        v.lat = lat; v.nwr = nwr; v.nrd = nrd; v.rsp = rsp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for cmd_ready (bounded), presents one command for one edge.
    // Returns in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] a2,
                         input logic [8:0] len, input logic [7:0] d);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w == 100) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_addr = a; cmd_addr2 = a2; cmd_len = len; cmd_data = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int lat, nwr, nrd, dcnt;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_addr = '0; cmd_addr2 = '0; cmd_len = '0; cmd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h20] <= 8'h01; mem[8'h21] <= 8'h02; mem[8'h22] <= 8'h03;
        mem[8'h60] <= 8'h07; mem[8'h61] <= 8'h08; mem[8'h62] <= 8'h09;
        for (int i = 0; i < 8; i++) mem[8'h80 + i] <= 8'hE0 + 8'(i);

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wr_en", 32'(ram_write_en), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        rst = 1'b0;
        tick();

        // WRITE 0x10=0xA5 then READ 0x10, cycle-accurate
        issue(C_WRITE, 8'h10, 8'h00, 9'd0, 8'hA5);
        chk("wr_t1_en", 32'(ram_write_en), 32'd1);
        chk("wr_t1_addr", 32'(ram_write_adress), 32'h10);
        chk("wr_t1_data", 32'(ram_data_in), 32'hA5);
        chk("wr_t1_ready", 32'(cmd_ready), 32'd0);
        chk("wr_t1_done", 32'(done), 32'd0);
        tick();
        chk("wr_t2_done", 32'(done), 32'd1);
        chk("wr_t2_en", 32'(ram_write_en), 32'd0);
        chk("wr_t2_ready", 32'(cmd_ready), 32'd1);
        $display("txn WRITE addr=10 data=a5");
        issue(C_READ, 8'h10, 8'h00, 9'd0, 8'h00);
        chk("rd_t1_en", 32'(ram_rd_en), 32'd1);
        chk("rd_t1_addr", 32'(ram_rd_adress), 32'h10);
        chk("rd_t1_wr_en", 32'(ram_write_en), 32'd0);
        tick();
        chk("rd_t2_en", 32'(ram_rd_en), 32'd0);
        chk("rd_t2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_t3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_t3_done", 32'(done), 32'd1);
        chk("rd_t3_data", 32'(rsp_data), 32'hA5);
        chk("rd_t3_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("rd_t4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rd_t4_data_held", 32'(rsp_data), 32'hA5);
        $display("txn READ addr=10 data=%h", rsp_data);

        // Command table: op, addr, addr2, len, data, latency to done, writes, reads, rsp
        vecs.push_back(mk(C_FILL,  8'hFE, 8'h00, 9'd4, 8'h3C, 5, 4, 0, 8'h00));
        vecs.push_back(mk(C_READ,  8'hFE, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h3C));
        vecs.push_back(mk(C_READ,  8'hFF, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h3C));
        vecs.push_back(mk(C_READ,  8'h00, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h3C));
        vecs.push_back(mk(C_READ,  8'h01, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h3C));
        vecs.push_back(mk(C_READ,  8'h02, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h00));
        vecs.push_back(mk(C_READ,  8'hFD, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h00));
        vecs.push_back(mk(C_COPY,  8'h20, 8'h40, 9'd3, 8'h00, 10, 3, 3, 8'h00));
        vecs.push_back(mk(C_READ,  8'h40, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h01));
        vecs.push_back(mk(C_READ,  8'h41, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h02));
        vecs.push_back(mk(C_READ,  8'h42, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h03));
        vecs.push_back(mk(C_COPY,  8'h20, 8'h90, 9'd0, 8'h00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(C_FILL,  8'h91, 8'h00, 9'd0, 8'h55, 1, 0, 0, 8'h00));
        vecs.push_back(mk(C_READ,  8'h90, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h00));
        vecs.push_back(mk(C_READ,  8'h91, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h00));
        vecs.push_back(mk(C_COPY,  8'h60, 8'h61, 9'd3, 8'h00, 10, 3, 3, 8'h00));
        vecs.push_back(mk(C_READ,  8'h61, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h07));
        vecs.push_back(mk(C_READ,  8'h62, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h07));
        vecs.push_back(mk(C_READ,  8'h63, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h07));
        vecs.push_back(mk(C_COPY,  8'hFF, 8'h30, 9'd2, 8'h00, 7, 2, 2, 8'h00));
        vecs.push_back(mk(C_READ,  8'h30, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h3C));
        vecs.push_back(mk(C_READ,  8'h31, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h3C));
        vecs.push_back(mk(C_FILL,  8'h70, 8'h00, 9'd1, 8'h5A, 2, 1, 0, 8'h00));
        vecs.push_back(mk(C_READ,  8'h70, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h5A));
        vecs.push_back(mk(C_READ,  8'h71, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h00));
        vecs.push_back(mk(C_WRITE, 8'h50, 8'h00, 9'd0, 8'h11, 2, 1, 0, 8'h00));
        vecs.push_back(mk(C_READ,  8'h50, 8'h00, 9'd0, 8'h00, 3, 0, 1, 8'h11));

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].addr2, vecs[i].len, vecs[i].data);
            lat = 1; nwr = 0; nrd = 0;
            while (done !== 1'b1 && lat < 500) begin
                nwr += int'(ram_write_en);
                nrd += int'(ram_rd_en);
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_writes", i), 32'(nwr), 32'(vecs[i].nwr));
            chk($sformatf("v%0d_reads", i), 32'(nrd), 32'(vecs[i].nrd));
            if (vecs[i].op == C_READ) begin
                chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
                chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].rsp));
            end else begin
                chk($sformatf("v%0d_no_rsp", i), 32'(rsp_valid), 32'd0);
            end
            if (vecs[i].len == 9'd0 && (vecs[i].op == C_COPY || vecs[i].op == C_FILL)) begin
                chk($sformatf("v%0d_len0_ready_t1", i), 32'(cmd_ready), 32'd0);
                tick();
                chk($sformatf("v%0d_len0_ready_t2", i), 32'(cmd_ready), 32'd1);
            end
            $display("txn vec=%0d op=%0d addr=%h addr2=%h len=%0d data=%h lat=%0d wr=%0d rd=%0d rsp=%h",
                     i, vecs[i].op, vecs[i].addr, vecs[i].addr2, vecs[i].len, vecs[i].data,
                     lat, nwr, nrd, rsp_data);
        end

        // Reset in the middle of FILL len=8 at 0x80 (during the write to 0x81)
        issue(C_FILL, 8'h80, 8'h00, 9'd8, 8'h99);
        chk("rf_t1_addr", 32'(ram_write_adress), 32'h80);
        tick();
        chk("rf_t2_en", 32'(ram_write_en), 32'd1);
        chk("rf_t2_addr", 32'(ram_write_adress), 32'h81);
        rst = 1'b1;
        tick();
        chk("rf_wr_en", 32'(ram_write_en), 32'd0);
        chk("rf_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rf_busy", 32'(busy), 32'd0);
        chk("rf_ready", 32'(cmd_ready), 32'd1);
        chk("rf_done", 32'(done), 32'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            dcnt += int'(done) + int'(ram_write_en);
        end
        chk("rf_quiet_after", 32'(dcnt), 32'd0);
        chk("rf_mem_80", 32'(mem[8'h80]), 32'h99);
        chk("rf_mem_81", 32'(mem[8'h81]), 32'h99);
        for (int k = 2; k < 8; k++)
            chk($sformatf("rf_mem_%0h", 8'h80 + k), 32'(mem[8'h80 + k]), 32'(8'hE0 + k));
        $display("txn FILL addr=80 len=8 aborted by reset");

        // cmd_valid held while busy with a different command
        cmd_op = C_READ; cmd_addr = 8'h70; cmd_valid = 1'b1;
        tick();
        cmd_op = C_WRITE; cmd_addr = 8'h72; cmd_data = 8'h77;
        chk("ig_t1_rd_en", 32'(ram_rd_en), 32'd1);
        tick();
        chk("ig_t2_wr_en", 32'(ram_write_en), 32'd0);
        chk("ig_t2_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("ig_t3_wr_en", 32'(ram_write_en), 32'd0);
        chk("ig_t3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ig_t3_rsp_data", 32'(rsp_data), 32'h5A);
        tick();
        cmd_valid = 1'b0;
        chk("ig_t4_wr_en", 32'(ram_write_en), 32'd1);
        chk("ig_t4_wr_addr", 32'(ram_write_adress), 32'h72);
        chk("ig_t4_wr_data", 32'(ram_data_in), 32'h77);
        tick();
        chk("ig_t5_done", 32'(done), 32'd1);
        $display("txn READ addr=70 then held WRITE addr=72 data=77");

        // Back-to-back READs with cmd_valid held high
        cmd_op = C_READ; cmd_addr = 8'h72; cmd_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("b2b_k%0d_rsp_valid", k), 32'(rsp_valid), 32'((k % 3) == 0));
            if ((k % 3) == 0) chk($sformatf("b2b_k%0d_rsp_data", k), 32'(rsp_data), 32'h77);
            $display("txn b2b cycle=%0d rsp_valid=%0d rsp_data=%h", k, rsp_valid, rsp_data);
        end
        cmd_valid = 1'b0;
        tick(); tick(); tick(); tick();

        chk("strobe_overlap", 32'(overlap_cnt), 32'd0);
        chk("pulse_in_reset", 32'(rstpulse_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
